// File: rtl/nios2_debug_cmd_sysclk_bridge.sv
// Brings TCK-domain update-DR/IR strobes into clk, queues {ir,sr} commands and replays them as one-hot pulses.
// Pulse appears SYNC_STAGES+1 edges after vs_udr is first sampled high; accept_en gates pops, full FIFO drops and sets overflow.
module nios2_debug_cmd_sysclk_bridge #(
  parameter int DATA_W       = 38,
  parameter int IR_W         = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int FLUSH_ON_UIR = 1,
  localparam int NUM_CH = 2**IR_W,
  localparam int PTR_W  = $clog2(FIFO_DEPTH),
  localparam int LVL_W  = PTR_W + 1,
  localparam int ENT_W  = IR_W + DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vs_udr,
  input  logic              vs_uir,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DATA_W-1:0] sr,
  input  logic              accept_en,
  input  logic              clear_overflow,
  output logic [DATA_W-1:0] jdo,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [NUM_CH-1:0] take_action,
  output logic [NUM_CH-1:0] take_no_action,
  output logic              uir_pulse,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow
);

  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d, uir_sync_q, uir_sync_d;
  logic                   udr_edge_q, udr_edge_d, uir_edge_q, uir_edge_d;
  logic                   uir_evt_q, uir_evt_d, uir_pulse_q, uir_pulse_d;
  logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d, level_base;
  logic [DATA_W-1:0]      jdo_q, jdo_d;
  logic [IR_W-1:0]        cmd_ir_q, cmd_ir_d;
  logic [NUM_CH-1:0]      take_action_q, take_action_d, take_no_action_q, take_no_action_d;
  logic                   overflow_q, overflow_d;
  logic                   udr_evt, uir_evt, flush, pop, push, full;
  logic [ENT_W-1:0]       head;

  assign udr_evt = udr_sync_q[SYNC_STAGES-1] & ~udr_edge_q;
  assign uir_evt = uir_sync_q[SYNC_STAGES-1] & ~uir_edge_q;

  always_comb begin
    udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    udr_edge_d = udr_sync_q[SYNC_STAGES-1];
    uir_edge_d = uir_sync_q[SYNC_STAGES-1];
    uir_evt_d   = uir_evt;
    uir_pulse_d = uir_evt_q;

    flush = uir_evt && (FLUSH_ON_UIR != 0);
    full  = (level_q == LVL_W'(FIFO_DEPTH));
    pop   = accept_en && (level_q != '0) && !flush;
    // A flush empties the FIFO first, so a coincident push always lands.
    push  = udr_evt && (flush || !full || pop);

    rd_ptr_d   = flush ? wr_ptr_q : rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    level_base = flush ? '0 : level_q - LVL_W'(pop);
    level_d    = level_base + LVL_W'(push);

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {ir_in, sr};

    head             = mem_q[rd_ptr_q];
    jdo_d            = jdo_q;
    cmd_ir_d         = cmd_ir_q;
    take_action_d    = '0;
    take_no_action_d = '0;
    if (pop) begin
      jdo_d    = head[DATA_W-1:0];
      cmd_ir_d = head[ENT_W-1:DATA_W];
      if (head[DATA_W-1]) take_action_d    = NUM_CH'(1) << head[ENT_W-1:DATA_W];
      else                take_no_action_d = NUM_CH'(1) << head[ENT_W-1:DATA_W];
    end

    overflow_d = (udr_evt && !push) | (overflow_q & ~clear_overflow);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      udr_sync_q       <= '1;
      uir_sync_q       <= '1;
      udr_edge_q       <= 1'b1;
      uir_edge_q       <= 1'b1;
      uir_evt_q        <= 1'b0;
      uir_pulse_q      <= 1'b0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      level_q          <= '0;
      jdo_q            <= '0;
      cmd_ir_q         <= '0;
      take_action_q    <= '0;
      take_no_action_q <= '0;
      overflow_q       <= 1'b0;
    end else begin
      udr_sync_q       <= udr_sync_d;
      uir_sync_q       <= uir_sync_d;
      udr_edge_q       <= udr_edge_d;
      uir_edge_q       <= uir_edge_d;
      uir_evt_q        <= uir_evt_d;
      uir_pulse_q      <= uir_pulse_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      level_q          <= level_d;
      jdo_q            <= jdo_d;
      cmd_ir_q         <= cmd_ir_d;
      take_action_q    <= take_action_d;
      take_no_action_q <= take_no_action_d;
      overflow_q       <= overflow_d;
    end
  end

  // Storage needs no reset: the level counter alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign jdo            = jdo_q;
  assign cmd_ir         = cmd_ir_q;
  assign take_action    = take_action_q;
  assign take_no_action = take_no_action_q;
  assign uir_pulse      = uir_pulse_q;
  assign fifo_level     = level_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_nios2_debug_cmd_sysclk_bridge.sv
// Bench for nios2_debug_cmd_sysclk_bridge: directed literal checks plus a randomized run against a queue-based model.
module tb_nios2_debug_cmd_sysclk_bridge;
  localparam int DATA_W = 38;
  localparam int IR_W   = 2;
  localparam int S      = 2;
  localparam int DEPTH  = 4;
  localparam int NUM_CH = 4;
  localparam int LVL_W  = 3;
  localparam logic [DATA_W-1:0] ACT = 38'h20_0000_0000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              vs_udr = 1'b1;
  logic              vs_uir = 1'b1;
  logic [IR_W-1:0]   ir_in = '0;
  logic [DATA_W-1:0] sr = '0;
  logic              accept_en = 1'b1;
  logic              clear_overflow = 1'b0;
  logic [DATA_W-1:0] jdo;
  logic [IR_W-1:0]   cmd_ir;
  logic [NUM_CH-1:0] take_action, take_no_action;
  logic              uir_pulse;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;

  nios2_debug_cmd_sysclk_bridge dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .accept_en(accept_en), .clear_overflow(clear_overflow),
    .jdo(jdo), .cmd_ir(cmd_ir), .take_action(take_action), .take_no_action(take_no_action),
    .uir_pulse(uir_pulse), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: commands are a queue; an event at edge k is a 0->1 step between
  // the input samples taken at edges k-S-1 and k-S (samples at reset edges count as 1).
  logic [IR_W+DATA_W-1:0] mq[$];
  bit                     uh[$], ih[$];
  logic [IR_W+DATA_W-1:0] ent;
  logic [DATA_W-1:0]      m_jdo;
  logic [IR_W-1:0]        m_ir;
  logic [NUM_CH-1:0]      m_ta, m_tna;
  bit m_uir, m_uir_pend, m_ovf, ue, ie, m_pop, started;

  always @(posedge clk) begin
    started <= 1'b1;
    if (!reset_n) begin
      mq.delete(); uh.delete(); ih.delete();
      for (int i = 0; i < S + 1; i++) begin uh.push_back(1'b1); ih.push_back(1'b1); end
      m_jdo = '0; m_ir = '0; m_ta = '0; m_tna = '0;
      m_uir = 0; m_uir_pend = 0; m_ovf = 0;
    end else begin
      ue = uh[1] && !uh[0];
      ie = ih[1] && !ih[0];
      void'(uh.pop_front()); uh.push_back(vs_udr);
      void'(ih.pop_front()); ih.push_back(vs_uir);
      m_uir = m_uir_pend;
      m_uir_pend = ie;
      m_ta = '0; m_tna = '0;
      m_pop = accept_en && (mq.size() > 0) && !ie;
      if (ie) mq.delete();
      if (m_pop) begin
        ent = mq.pop_front();
        m_jdo = ent[DATA_W-1:0];
        m_ir  = ent[IR_W+DATA_W-1:DATA_W];
        if (ent[DATA_W-1]) m_ta = NUM_CH'(1) << m_ir;
        else               m_tna = NUM_CH'(1) << m_ir;
      end
      if (clear_overflow) m_ovf = 0;
      if (ue) begin
        if (mq.size() < DEPTH) mq.push_back({ir_in, sr});
        else m_ovf = 1;
      end
    end
  end

  // Every-cycle comparison against the model, plus pulse bookkeeping for directed checks.
  int pulse_cnt = 0;
  int uir_cnt = 0;
  logic [NUM_CH-1:0] last_ta = '0, last_tna = '0;
  always @(negedge clk) begin
    if (started) begin
      chk("jdo", 64'(jdo), 64'(m_jdo));
      chk("cmd_ir", 64'(cmd_ir), 64'(m_ir));
      chk("take_action", 64'(take_action), 64'(m_ta));
      chk("take_no_action", 64'(take_no_action), 64'(m_tna));
      chk("uir_pulse", 64'(uir_pulse), 64'(m_uir));
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
    end
    if ((take_action | take_no_action) != '0) begin
      pulse_cnt++;
      last_ta = take_action;
      last_tna = take_no_action;
    end
    if (uir_pulse) uir_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] d);
    ir_in = ir; sr = d; vs_udr = 1'b1;
    cyc(S + 2);
    vs_udr = 1'b0;
    cyc(S + 2);
  endtask

  int p0, u0, ucnt, icnt;

  initial begin
    // Reset with both strobes already high: release must not create events.
    cyc(3);
    reset_n = 1'b1;
    cyc(6);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_pulses", 64'(pulse_cnt), 64'd0);
    chk("rst_uir", 64'(uir_cnt), 64'd0);
    chk("rst_jdo", 64'(jdo), 64'd0);
    vs_udr = 1'b0; vs_uir = 1'b0;
    cyc(S + 2);

    // Single command: pulse only after the 4th edge from E0.
    ir_in = 2'd2; sr = 38'h20_0000_0ABC; vs_udr = 1'b1;
    cyc(3);
    chk("single_before", 64'(take_action), 64'd0);
    cyc(1);
    chk("single_ta", 64'(take_action), 64'b0100);
    chk("single_jdo", 64'(jdo), 64'h20_0000_0ABC);
    cyc(1);
    chk("single_after", 64'(take_action), 64'd0);
    chk("single_hold", 64'(jdo), 64'h20_0000_0ABC);
    vs_udr = 1'b0;
    cyc(S + 2);

    // Fill and overflow, then in-order drain.
    accept_en = 1'b0;
    for (int v = 1; v <= 5; v++) send(2'd0, DATA_W'(v));
    chk("fill_level", 64'(fifo_level), 64'd4);
    chk("fill_ovf", 64'(overflow), 64'd1);
    accept_en = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      cyc(1);
      chk("drain_jdo", 64'(jdo), 64'(v));
      chk("drain_tna", 64'(take_no_action), 64'b0001);
    end
    chk("drain_level", 64'(fifo_level), 64'd0);
    clear_overflow = 1'b1;
    cyc(1);
    clear_overflow = 1'b0;
    chk("ovf_clear", 64'(overflow), 64'd0);

    // Full FIFO with a pop in the same cycle as the push.
    accept_en = 1'b0;
    for (int v = 11; v <= 14; v++) send(2'd3, ACT | DATA_W'(v));
    chk("full_level", 64'(fifo_level), 64'd4);
    ir_in = 2'd3; sr = ACT | DATA_W'(15); vs_udr = 1'b1;
    cyc(2);
    accept_en = 1'b1;
    cyc(1);
    chk("fullpop_level", 64'(fifo_level), 64'd4);
    chk("fullpop_ovf", 64'(overflow), 64'd0);
    chk("fullpop_jdo", 64'(jdo), 64'(ACT | DATA_W'(11)));
    for (int v = 12; v <= 15; v++) begin
      cyc(1);
      chk("fullpop_order", 64'(jdo), 64'(ACT | DATA_W'(v)));
      chk("fullpop_ta", 64'(take_action), 64'b1000);
    end
    chk("fullpop_empty", 64'(fifo_level), 64'd0);
    vs_udr = 1'b0;
    cyc(S + 2);

    // Action bit clear.
    p0 = pulse_cnt;
    send(2'd1, 38'h00_0000_0055);
    chk("noact_count", 64'(pulse_cnt - p0), 64'd1);
    chk("noact_tna", 64'(last_tna), 64'b0010);
    chk("noact_ta", 64'(last_ta), 64'd0);

    // Flush coincident with a push.
    accept_en = 1'b0;
    for (int v = 21; v <= 23; v++) send(2'd0, DATA_W'(v));
    chk("flush_pre", 64'(fifo_level), 64'd3);
    u0 = uir_cnt;
    ir_in = 2'd0; sr = DATA_W'(7); vs_udr = 1'b1; vs_uir = 1'b1;
    cyc(3);
    chk("flush_level", 64'(fifo_level), 64'd1);
    cyc(1);
    chk("flush_uir", 64'(uir_pulse), 64'd1);
    vs_udr = 1'b0; vs_uir = 1'b0;
    cyc(S + 2);
    chk("flush_uir_cnt", 64'(uir_cnt - u0), 64'd1);
    accept_en = 1'b1;
    cyc(1);
    chk("flush_jdo", 64'(jdo), 64'd7);
    cyc(2);

    // Randomized traffic, with one reset in the middle.
    ucnt = 0; icnt = 0;
    for (int c = 0; c < 4000; c++) begin
      case ((c / 500) % 3)
        0:       accept_en = ($urandom_range(0, 7) == 0);
        1:       accept_en = ($urandom_range(0, 1) == 0);
        default: accept_en = ($urandom_range(0, 7) != 0);
      endcase
      clear_overflow = ($urandom_range(0, 31) == 0);
      if (ucnt > 0) ucnt--;
      else if (vs_udr) begin
        vs_udr = 1'b0;
        ir_in = IR_W'($urandom());
        sr = DATA_W'({$urandom(), $urandom()});
        ucnt = S + 1 + $urandom_range(0, 3);
      end else if ($urandom_range(0, 1) == 0) begin
        vs_udr = 1'b1;
        ucnt = S + 1 + $urandom_range(0, 4);
      end
      if (icnt > 0) icnt--;
      else if (vs_uir) begin
        vs_uir = 1'b0;
        icnt = S + 1 + $urandom_range(0, 5);
      end else if ($urandom_range(0, 15) == 0) begin
        vs_uir = 1'b1;
        icnt = S + 1 + $urandom_range(0, 3);
      end
      reset_n = !(c == 2000 || c == 2001);
      cyc(1);
    end
    vs_udr = 1'b0; vs_uir = 1'b0; accept_en = 1'b1; clear_overflow = 1'b0;
    cyc(2 * S + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/nios2_debug_cmd_sysclk_bridge.md
# nios2_debug_cmd_sysclk_bridge

Parametrised successor to the Nios II debug-slave system-clock side. Takes the virtual-JTAG update strobes and captured scan data from the TCK domain, synchronises them into `clk`, buffers each update-DR command in a small FIFO, and replays the commands as one-cycle `take_action` / `take_no_action` pulses with a held `jdo` word. Generalises the fixed 2-bit-IR / 38-bit design to any IR width, data width and channel count. It adds command buffering, flow control, overflow reporting and a flush on update-IR.

## Interface
- `DATA_W`, default 38: scan data width; bit `DATA_W-1` is the action bit.
- `IR_W`, default 2: instruction register width; channel count `NUM_CH = 2**IR_W`.
- `SYNC_STAGES`, default 2: synchroniser depth, at least 2.
- `FIFO_DEPTH`, default 4: command FIFO entries, power of two, at least 2.
- `FLUSH_ON_UIR`, default 1: when 1, an update-IR event empties the FIFO.

Ports:
- `clk`, in, 1: system clock; the only clock.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `vs_udr`, in, 1: update-DR level from the TCK domain; asynchronous to `clk`.
- `vs_uir`, in, 1: update-IR level from the TCK domain; asynchronous to `clk`.
- `ir_in`, in, `IR_W`: current IR; stable from before `vs_udr` rises until after it falls.
- `sr`, in, `DATA_W`: scan register; same stability rule as `ir_in`.
- `accept_en`, in, 1: consumer allows one pop per cycle.
- `clear_overflow`, in, 1: clears the sticky overflow flag.
- `jdo`, out, `DATA_W`: data of the last popped command; held until the next pop.
- `cmd_ir`, out, `IR_W`: IR of the last popped command.
- `take_action`, out, `NUM_CH`: one-hot, one-cycle pulse; bit `cmd_ir` is set when the action bit is 1.
- `take_no_action`, out, `NUM_CH`: one-hot, one-cycle pulse; bit `cmd_ir` is set when the action bit is 0.
- `uir_pulse`, out, 1: one-cycle pulse per update-IR event.
- `fifo_level`, out, `clog2(FIFO_DEPTH)+1`: current occupancy.
- `overflow`, out, 1: sticky; set when a command is dropped.

## Operation
- **Synchroniser:** `vs_udr` and `vs_uir` each pass through `SYNC_STAGES` flops plus one edge register.
  - The chain and the edge register reset to 1, so a level already high at reset release produces no event.
  - An event is a synchronised 0→1 transition and lasts one cycle.
- **UDR event:** pushes `{ir_in, sr}` into the FIFO.
  - Full and no pop this cycle: the entry is dropped and `overflow` is set.
  - Full with a pop in the same cycle: the push succeeds and the level stays at `FIFO_DEPTH`.
- **UIR event:** `uir_pulse` goes high the next cycle.
  - With `FLUSH_ON_UIR=1` the FIFO empties and any pop that cycle is suppressed.
  - If a UDR event lands in the same cycle, the flush applies first, then the push; the level ends at 1.
- **Pop:** happens when `accept_en=1`, the FIFO is not empty and no flush occurs.
  - Registers `jdo` and `cmd_ir` from the head entry.
  - Asserts exactly one bit of `take_action` or `take_no_action`, at index `cmd_ir`, for one cycle.
  - With no pop, both pulse vectors are 0 and `jdo` / `cmd_ir` hold.
- **Overflow:** `clear_overflow` clears the flag. If a drop happens in the same cycle, set wins.
- **Pointers:** `log2(FIFO_DEPTH)` bits, wrapping naturally; the level counter resolves full vs empty.
- **Ordering:** commands pop in strict FIFO order.

## Timing
- **Reset** (while `reset_n=0` at a `clk` edge):
  - `jdo`=0, `cmd_ir`=0, `take_action`=0, `take_no_action`=0, `uir_pulse`=0, `fifo_level`=0, `overflow`=0.
  - Synchroniser and edge registers are 1.
  - A reset mid-operation discards FIFO contents and any in-flight event.
- **UDR latency:** let E0 be the first edge sampling `vs_udr`=1.
  - The FIFO write happens at edge `E(SYNC_STAGES)`.
  - With `accept_en=1` the pop happens at `E(SYNC_STAGES+1)`; pulses and the new `jdo` are visible after that edge.
  - With `SYNC_STAGES=2`, the pulse appears after the 4th edge.
- **UIR latency:** `uir_pulse` follows the same path, visible after `E(SYNC_STAGES+1)`.
- **Source requirement:** successive `vs_udr` highs and lows must each last at least `SYNC_STAGES+1` clk cycles. Shorter glitches may be lost; this is not an error condition.
- **Throughput:** `fifo_level` updates the cycle after the push or pop; sustained rate is one pop per cycle.

## Test plan
- **Reset:** hold `vs_udr`=1 through reset, release → no pulse, `fifo_level`=0, all outputs 0.
- **Single command:** `ir_in`=2, `sr`=38'h20_0000_0ABC, one UDR, `accept_en`=1 → `take_action`=4'b0100 for exactly 1 cycle, visible after the 4th edge from E0; `jdo`=38'h20_0000_0ABC held.
- **Fill and overflow:** `accept_en`=0, 5 UDRs with `sr`=1..5 → `fifo_level`=4, `overflow`=1.
  - Then `accept_en`=1 → pops in order 1,2,3,4 on 4 consecutive cycles, level 0.
  - `clear_overflow` → `overflow`=0.
- **Full with same-cycle pop:** `fifo_level`=4, `accept_en` raised on the same cycle as a UDR event → no overflow, level stays 4, the new entry pops last.
- **Action bit clear:** `ir_in`=1, `sr[37]`=0 → `take_no_action`=4'b0010, `take_action`=0.
- **Flush:** 3 queued entries, UIR event coincident with a UDR carrying `sr`=7 → `uir_pulse` 1 cycle, level ends at 1, the next pop gives `jdo`=7.
